prog_master: RTL and testbench

PROG_MASTER -- requirements
Module: prog_master

---
 rtl/prog_master.sv | 155 +++++++++++++++
 tb/tb_prog_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_master.sv
// Host-side programmer for a small processor: shifts 12-bit instruction
// frames out serially over csi_n/mosi, then supervises a program run
// with a done handshake and a cycle-count timeout.
module prog_master #(
  parameter int unsigned RUN_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       csi_n,
  output logic       csd_n,
  output logic       mosi,
  output logic       proc_en,
  input  logic       done_in,
  output logic       busy,
  output logic       run_done,
  output logic       timed_out
);

  localparam int unsigned FRAME_W = 12;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned CNT_W   = 8;

  localparam logic [BIT_W-1:0] SHIFT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] GAP_LAST   = BIT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(RUN_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    RUN   = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [FRAME_W-1:0]   frame, frame_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [CNT_W-1:0]     run_cnt, run_cnt_nxt;
  logic                 seen_low, seen_low_nxt;
  logic                 timed_out_nxt;
  logic                 run_done_nxt;
  logic                 finish;
  logic                 at_limit;

  // State and datapath registers; reset drops any frame or run in progress
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame     <= '0;
      bit_cnt   <= '0;
      run_cnt   <= '0;
      seen_low  <= 1'b0;
      timed_out <= 1'b0;
      run_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame     <= frame_nxt;
      bit_cnt   <= bit_cnt_nxt;
      run_cnt   <= run_cnt_nxt;
      seen_low  <= seen_low_nxt;
      timed_out <= timed_out_nxt;
      run_done  <= run_done_nxt;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_nxt     = state;
    frame_nxt     = frame;
    bit_cnt_nxt   = bit_cnt;
    run_cnt_nxt   = run_cnt;
    seen_low_nxt  = seen_low;
    timed_out_nxt = timed_out;
    run_done_nxt  = 1'b0;
    cmd_ready     = 1'b0;
    csi_n         = 1'b1;
    csd_n         = 1'b1;
    mosi          = 1'b0;
    busy          = (state != IDLE);
    // Completion only counts once the processor has actually started (done went low)
    finish        = seen_low & done_in;
    at_limit      = (run_cnt == TIMEOUT);
    proc_en       = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_op) begin
            state_nxt     = RUN;
            run_cnt_nxt   = '0;
            seen_low_nxt  = 1'b0;
            timed_out_nxt = 1'b0;
          end else begin
            state_nxt = LEAD;
            frame_nxt = {cmd_data, cmd_addr};
          end
        end
      end

      LEAD: begin
        csi_n       = 1'b0;
        state_nxt   = SHIFT;
        bit_cnt_nxt = '0;
      end

      SHIFT: begin
        csi_n = 1'b0;
        mosi  = frame[bit_cnt];
        if (bit_cnt == SHIFT_LAST) begin
          state_nxt   = GAP;
          bit_cnt_nxt = '0;
        end else begin
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
        end
      end

      GAP: begin
        if (bit_cnt == GAP_LAST) begin
          state_nxt   = IDLE;
          bit_cnt_nxt = '0;
        end else begin
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
        end
      end

      RUN: begin
        // Enable drops in the very cycle done is reported so the core cannot restart
        proc_en     = ~finish & ~at_limit;
        run_cnt_nxt = run_cnt + CNT_W'(1);
        if (!done_in) begin
          seen_low_nxt = 1'b1;
        end
        if (finish) begin
          state_nxt    = IDLE;
          run_done_nxt = 1'b1;
        end else if (at_limit) begin
          state_nxt     = IDLE;
          run_done_nxt  = 1'b1;
          timed_out_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_prog_master.sv
// Directed bench for prog_master: write frames decoded by a processor
// model and checked against a frame scoreboard, runs checked against
// an expected-outcome scoreboard, plus reset behaviour.
module tb_prog_master;

  localparam int unsigned TO = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       csi_n;
  logic       csd_n;
  logic       mosi;
  logic       proc_en;
  logic       done_in;
  logic       busy;
  logic       run_done;
  logic       timed_out;

  typedef struct packed {
    logic       to;
    logic [7:0] last;
  } run_exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] frame_q[$];
  run_exp_t    run_q[$];
  logic [7:0]  icache[16];

  prog_master #(.RUN_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .csi_n     (csi_n),
    .csd_n     (csd_n),
    .mosi      (mosi),
    .proc_en   (proc_en),
    .done_in   (done_in),
    .busy      (busy),
    .run_done  (run_done),
    .timed_out (timed_out)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence wedges
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the LEAD-cycle sample point; follows the frame to the ready cycle
  task automatic watch_frame(input string tag);
    logic [11:0] bits;
    logic [11:0] exp;
    int          lows;
    lows = 0;
    bits = '0;
    chk({tag, "_lead_csi"}, 32'(csi_n), 0);
    chk({tag, "_lead_mosi"}, 32'(mosi), 0);
    if (csi_n == 1'b0) lows++;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (csi_n == 1'b0) lows++;
      bits[k] = mosi;
    end
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      chk({tag, "_gap_csi"}, 32'(csi_n), 1);
      chk({tag, "_gap_mosi"}, 32'(mosi), 0);
      chk({tag, "_gap_busy"}, 32'(busy), 1);
      chk({tag, "_gap_ready"}, 32'(cmd_ready), 0);
    end
    @(negedge clk);
    chk({tag, "_ready15"}, 32'(cmd_ready), 1);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    chk({tag, "_no_run_done"}, 32'(run_done), 0);
    chk({tag, "_csd"}, 32'(csd_n), 1);
    chk({tag, "_csi_low_cnt"}, 32'(lows), 13);
    icache[bits[3:0]] = bits[11:4];
    if (frame_q.size() == 0) begin
      chk({tag, "_frame_q_empty"}, 1, 0);
    end else begin
      exp = frame_q.pop_front();
      chk({tag, "_frame"}, 32'(bits), 32'(exp));
    end
  endtask

  // Enters at an IDLE sample point; ends at the ready cycle after the frame
  task automatic do_write(input string tag, input logic [3:0] a, input logic [7:0] d);
    frame_q.push_back({d, a});
    chk({tag, "_ready"}, 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_addr  = a;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = 4'($urandom);
    cmd_data  = 8'($urandom);
    cmd_op    = 1'($urandom);
    done_in   = 1'($urandom);
    watch_frame(tag);
  endtask

  // done_in is low for RUN cycles lf..lt; last is the expected final RUN cycle
  task automatic run_case(input string tag, input int lf, input int lt,
                          input int last, input logic to);
    run_exp_t e;
    int       end_c;
    logic     got;
    run_q.push_back({to, 8'(last)});
    chk({tag, "_ready"}, 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    done_in   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 1'($urandom);
    got       = 1'b0;
    end_c     = -1;
    for (int c = 0; c < 300; c++) begin
      done_in = (c >= lf && c <= lt) ? 1'b0 : 1'b1;
      #1;
      if (run_done) begin
        got   = 1'b1;
        end_c = c - 1;
        break;
      end
      if (c == 0) chk({tag, "_to_cleared"}, 32'(timed_out), 0);
      chk({tag, "_proc_en"}, 32'(proc_en), (c < last) ? 1 : 0);
      @(negedge clk);
    end
    if (!got) begin
      chk({tag, "_run_done_seen"}, 0, 1);
    end else begin
      e = run_q.pop_front();
      chk({tag, "_last_cycle"}, 32'(end_c), 32'(e.last));
      chk({tag, "_timed_out"}, 32'(timed_out), 32'(e.to));
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_ready_after"}, 32'(cmd_ready), 1);
      chk({tag, "_proc_en_idle"}, 32'(proc_en), 0);
      done_in = 1'($urandom);
      @(negedge clk);
      chk({tag, "_pulse_once"}, 32'(run_done), 0);
      chk({tag, "_to_hold"}, 32'(timed_out), 32'(e.to));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    done_in   = 1'b0;
    for (int i = 0; i < 16; i++) icache[i] = '0;
    repeat (3) @(negedge clk);

    chk("rst_csi", 32'(csi_n), 1);
    chk("rst_csd", 32'(csd_n), 1);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_proc_en", 32'(proc_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_run_done", 32'(run_done), 0);
    chk("rst_timed_out", 32'(timed_out), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(cmd_ready), 1);

    // Single write and processor-side decode
    do_write("w5", 4'h5, 8'hA3);
    chk("icache5", 32'(icache[5]), 32'h0A3);
    do_write("wf", 4'hF, 8'hFF);
    do_write("w0", 4'h0, 8'h00);
    chk("icache_f", 32'(icache[15]), 32'h0FF);

    // Back-to-back with cmd_valid held: ready returns in cycle 15 and is taken at once
    frame_q.push_back({8'h5C, 4'h9});
    frame_q.push_back({8'h81, 4'h6});
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_addr  = 4'h9;
    cmd_data  = 8'h5C;
    @(negedge clk);
    cmd_addr  = 4'h6;
    cmd_data  = 8'h81;
    watch_frame("b2b_a");
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_second_lead", 32'(busy), 1);
    watch_frame("b2b_b");
    chk("icache9", 32'(icache[9]), 32'h05C);
    chk("icache6", 32'(icache[6]), 32'h081);

    // Runs: normal completion, timeout, stuck done, coincident finish, quick finish
    run_case("run_norm", 1, 9, 10, 1'b0);
    run_case("run_tmo", 0, 1000, TO, 1'b1);
    do_write("w_after_to", 4'h3, 8'h3C);
    chk("to_held_write", 32'(timed_out), 1);
    run_case("run_coinc", 1, 19, TO, 1'b0);
    run_case("run_stuck", 1000, 1000, TO, 1'b1);
    run_case("run_quick", 0, 0, 1, 1'b0);

    // Reset in SHIFT cycle 6
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_addr  = 4'hA;
    cmd_data  = 8'hFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_shift_csi", 32'(csi_n), 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstf_csi", 32'(csi_n), 1);
    chk("rstf_mosi", 32'(mosi), 0);
    chk("rstf_busy", 32'(busy), 0);
    chk("rstf_run_done", 32'(run_done), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstf_after_csi", 32'(csi_n), 1);
      chk("rstf_after_run_done", 32'(run_done), 0);
      chk("rstf_after_ready", 32'(cmd_ready), 1);
    end

    // Reset mid-run after a timeout flag was set
    run_case("run_tmo2", 0, 1000, TO, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    done_in   = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_run_en", 32'(proc_en), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstr_proc_en", 32'(proc_en), 0);
    chk("rstr_busy", 32'(busy), 0);
    chk("rstr_run_done", 32'(run_done), 0);
    chk("rstr_timed_out", 32'(timed_out), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstr_after_run_done", 32'(run_done), 0);
      chk("rstr_after_ready", 32'(cmd_ready), 1);
      chk("rstr_after_proc_en", 32'(proc_en), 0);
    end

    // Controller still writes correctly after reset
    do_write("w_post", 4'hC, 8'h96);
    chk("icache_c", 32'(icache[12]), 32'h096);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
